// File: rtl/immgen_pipe.sv
// RISC-V immediate decoder with a ready/valid skid buffer. Decode happens before the
// output and skid registers, so both registers hold decoded results.
module immgen_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned TAG_W  = 8,
  parameter int unsigned CSR_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_imm_en,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    FmtNone = 3'd0,
    FmtI    = 3'd1,
    FmtS    = 3'd2,
    FmtB    = 3'd3,
    FmtU    = 3'd4,
    FmtJ    = 3'd5,
    FmtZ    = 3'd6
  } fmt_e;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            st_q, st_d;
  fmt_e              dec_fmt;
  logic [31:0]       dec_imm32;
  logic [XLEN-1:0]   dec_imm;

  logic [XLEN-1:0]   out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
  fmt_e              out_fmt_q, out_fmt_d, skid_fmt_q, skid_fmt_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d, skid_tag_q, skid_tag_d;
  logic              accept, drain;

  always_comb begin
    dec_fmt   = FmtNone;
    dec_imm32 = '0;
    if (in_instr[1:0] == 2'b11) begin
      unique case (in_instr[6:0])
        7'b0000011, 7'b0010011, 7'b1100111: begin
          dec_fmt   = FmtI;
          dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end
        7'b0011011: begin
          if (XLEN == 64) begin
            dec_fmt   = FmtI;
            dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
          end
        end
        7'b0100011: begin
          dec_fmt   = FmtS;
          dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        end
        7'b1100011: begin
          dec_fmt   = FmtB;
          dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                       in_instr[11:8], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          dec_fmt   = FmtU;
          dec_imm32 = {in_instr[31:12], 12'b0};
        end
        7'b1101111: begin
          dec_fmt   = FmtJ;
          dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                       in_instr[30:21], 1'b0};
        end
        7'b1110011: begin
          if (CSR_EN != 0 && in_instr[14]) begin
            dec_fmt   = FmtZ;
            dec_imm32 = {27'b0, in_instr[19:15]};
          end
        end
        default: ;
      endcase
    end
  end

  // Zimm has bit 31 clear, so a single sign-extension covers every format.
  assign dec_imm = XLEN'($signed(dec_imm32));

  assign in_ready  = (st_q != StFull);
  assign out_valid = (st_q != StEmpty);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    st_d       = st_q;
    out_imm_d  = out_imm_q;
    out_fmt_d  = out_fmt_q;
    out_tag_d  = out_tag_q;
    skid_imm_d = skid_imm_q;
    skid_fmt_d = skid_fmt_q;
    skid_tag_d = skid_tag_q;
    unique case (st_q)
      StEmpty: begin
        if (accept) begin
          out_imm_d = dec_imm;
          out_fmt_d = dec_fmt;
          out_tag_d = in_tag;
          st_d      = StOne;
        end
      end
      StOne: begin
        if (accept && drain) begin
          out_imm_d = dec_imm;
          out_fmt_d = dec_fmt;
          out_tag_d = in_tag;
        end else if (accept) begin
          skid_imm_d = dec_imm;
          skid_fmt_d = dec_fmt;
          skid_tag_d = in_tag;
          st_d       = StFull;
        end else if (drain) begin
          st_d = StEmpty;
        end
      end
      StFull: begin
        if (drain) begin
          out_imm_d = skid_imm_q;
          out_fmt_d = skid_fmt_q;
          out_tag_d = skid_tag_q;
          st_d      = StOne;
        end
      end
      default: st_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= StEmpty;
      out_imm_q  <= '0;
      out_fmt_q  <= FmtNone;
      out_tag_q  <= '0;
      skid_imm_q <= '0;
      skid_fmt_q <= FmtNone;
      skid_tag_q <= '0;
    end else begin
      st_q       <= st_d;
      out_imm_q  <= out_imm_d;
      out_fmt_q  <= out_fmt_d;
      out_tag_q  <= out_tag_d;
      skid_imm_q <= skid_imm_d;
      skid_fmt_q <= skid_fmt_d;
      skid_tag_q <= skid_tag_d;
    end
  end

  assign out_imm    = out_imm_q;
  assign out_fmt    = out_fmt_q;
  assign out_tag    = out_tag_q;
  assign out_imm_en = (out_fmt_q != FmtNone);

endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe: a 32-bit/CSR instance and a 64-bit/no-CSR instance share stimulus
// and are checked against an arithmetic decode model plus an in-order expectation queue.
module tb_immgen_pipe;

  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_instr = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_ready = 1'b0;

  logic          in_ready, out_valid, out_imm_en;
  logic [31:0]   out_imm;
  logic [2:0]    out_fmt;
  logic [TW-1:0] out_tag;
  logic          in_ready64, out_valid64, out_imm_en64;
  logic [63:0]   out_imm64;
  logic [2:0]    out_fmt64;
  logic [TW-1:0] out_tag64;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]    fmt32;
    logic [31:0]   imm32;
    logic [2:0]    fmt64;
    logic [63:0]   imm64;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];

  immgen_pipe #(.XLEN(32), .TAG_W(TW), .CSR_EN(1)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_imm_en(out_imm_en), .out_fmt(out_fmt), .out_tag(out_tag)
  );

  immgen_pipe #(.XLEN(64), .TAG_W(TW), .CSR_EN(0)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_imm_en(out_imm_en64), .out_fmt(out_fmt64), .out_tag(out_tag64)
  );

  always #5 clk = ~clk;

  function automatic longint sx(longint v, int bits);
    longint r = v;
    if (r >= (64'sd1 <<< (bits - 1))) r = r - (64'sd1 <<< bits);
    return r;
  endfunction

  function automatic void ref_dec(input logic [31:0] ins, input bit is64, input bit csr,
                                  output logic [2:0] fmt, output logic [63:0] imm);
    longint v = 0;
    fmt = 3'd0;
    if (ins[1:0] == 2'b11) begin
      case (ins[6:0])
        7'h03, 7'h13, 7'h67: begin fmt = 3'd1; v = sx(ins[31:20], 12); end
        7'h1B: if (is64) begin fmt = 3'd1; v = sx(ins[31:20], 12); end
        7'h23: begin fmt = 3'd2; v = sx(ins[31:25] * 32 + ins[11:7], 12); end
        7'h63: begin
          fmt = 3'd3;
          v = sx(ins[31] * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2, 13);
        end
        7'h37, 7'h17: begin fmt = 3'd4; v = sx(longint'(ins[31:12]) * 4096, 32); end
        7'h6F: begin
          fmt = 3'd5;
          v = sx(ins[31] * 1048576 + ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2, 21);
        end
        7'h73: if (csr && ins[14]) begin fmt = 3'd6; v = ins[19:15]; end
        default: ;
      endcase
    end
    imm = v;
  endfunction

  function automatic exp_t model(logic [31:0] ins, logic [TW-1:0] tag);
    exp_t e;
    logic [63:0] i32;
    ref_dec(ins, 1'b0, 1'b1, e.fmt32, i32);
    e.imm32 = i32[31:0];
    ref_dec(ins, 1'b1, 1'b0, e.fmt64, e.imm64);
    e.tag = tag;
    return e;
  endfunction

  // Advances one clock and updates the expectation queue from the handshakes.
  task automatic step();
    bit acc, drn;
    acc = in_valid && (exp_q.size() < 2);
    drn = out_ready && (exp_q.size() > 0);
    @(posedge clk);
    #1;
    if (drn) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(model(in_instr, in_tag));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63,
                             7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F};
    logic [31:0] ins = $urandom;
    if ($urandom_range(7) != 0) ins[6:0] = ops[$urandom_range(11)];
    return ins;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'hFFF00093;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid, out_imm, out_fmt, out_imm_en, out_tag, in_ready} !== {1'b0, 32'd0, 3'd0,
        1'b0, 8'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset32: got v=%0b imm=%h fmt=%0d en=%0b tag=%h rdy=%0b, want 0/0/0/0/0/1",
               out_valid, out_imm, out_fmt, out_imm_en, out_tag, in_ready);
    end
    n_vec++;
    if ({out_valid64, out_imm64, out_fmt64, out_imm_en64, out_tag64, in_ready64} !==
        {1'b0, 64'd0, 3'd0, 1'b0, 8'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset64: got v=%0b imm=%h fmt=%0d rdy=%0b, want 0/0/0/1",
               out_valid64, out_imm64, out_fmt64, in_ready64);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_directed();
    logic [31:0] ins [7] = '{32'hFFF00093, 32'h123450B7, 32'hFE000EE3, 32'h300FD073,
                             32'h00000010, 32'h00000033, 32'h0010009B};
    logic [2:0]  f32 [7] = '{3'd1, 3'd4, 3'd3, 3'd6, 3'd0, 3'd0, 3'd0};
    logic [31:0] i32 [7] = '{32'hFFFFFFFF, 32'h12345000, 32'hFFFFFFFC, 32'h0000001F,
                             32'h0, 32'h0, 32'h0};
    logic [2:0]  f64 [7] = '{3'd1, 3'd4, 3'd3, 3'd0, 3'd0, 3'd0, 3'd1};
    logic [63:0] i64 [7] = '{64'hFFFFFFFFFFFFFFFF, 64'h0000000012345000, 64'hFFFFFFFFFFFFFFFC,
                             64'h0, 64'h0, 64'h0, 64'h1};
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_instr = ins[k];
      in_tag   = 8'(k + 16);
      step();
      in_valid = 1'b0;
      n_vec++;
      if ({out_valid, out_fmt, out_imm, out_imm_en, out_tag} !==
          {1'b1, f32[k], i32[k], (f32[k] != 3'd0), 8'(k + 16)}) begin
        n_err++;
        $display("FAIL dir32[%0h]: got v=%0b fmt=%0d imm=%h en=%0b tag=%h, want fmt=%0d imm=%h",
                 ins[k], out_valid, out_fmt, out_imm, out_imm_en, out_tag, f32[k], i32[k]);
      end
      n_vec++;
      if ({out_valid64, out_fmt64, out_imm64, out_imm_en64} !==
          {1'b1, f64[k], i64[k], (f64[k] != 3'd0)}) begin
        n_err++;
        $display("FAIL dir64[%0h]: got v=%0b fmt=%0d imm=%h en=%0b, want fmt=%0d imm=%h",
                 ins[k], out_valid64, out_fmt64, out_imm64, out_imm_en64, f64[k], i64[k]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] got[$];
    bit acc;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    in_tag    = 8'd1;
    step();
    in_tag = 8'd2;
    step();
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_ready_low: got in_ready=%0b, want 0 after two accepts", in_ready);
    end
    in_tag = 8'd3;
    step();
    n_vec++;
    if ({in_ready, out_valid, out_tag} !== {1'b0, 1'b1, 8'd1}) begin
      n_err++;
      $display("FAIL b2b_hold: got rdy=%0b v=%0b tag=%0d, want 0/1/1",
               in_ready, out_valid, out_tag);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) got.push_back(out_tag);
      acc = in_valid && (exp_q.size() < 2);
      step();
      if (acc) in_valid = 1'b0;
    end
    n_vec++;
    if (got.size() != 3) begin
      n_err++;
      $display("FAIL b2b_count: got %0d results, want 3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (got[k] !== 8'(k + 1)) begin
          n_err++;
          $display("FAIL b2b_order[%0d]: got tag %0d, want %0d", k, got[k], k + 1);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_instr  = rand_instr();
      in_tag    = 8'($urandom);
      n_vec++;
      if ({in_ready, out_valid, in_ready64, out_valid64} !==
          {exp_q.size() < 2, exp_q.size() > 0, exp_q.size() < 2, exp_q.size() > 0}) begin
        n_err++;
        $display("FAIL rand_hs cyc %0d: got rdy=%0b v=%0b rdy64=%0b v64=%0b, want occ=%0d",
                 c, in_ready, out_valid, in_ready64, out_valid64, exp_q.size());
      end
      if (exp_q.size() > 0) begin
        n_vec++;
        if ({out_fmt, out_imm, out_imm_en, out_tag} !== {exp_q[0].fmt32, exp_q[0].imm32,
            exp_q[0].fmt32 != 3'd0, exp_q[0].tag}) begin
          n_err++;
          $display("FAIL rand32 cyc %0d: got fmt=%0d imm=%h en=%0b tag=%h, want %0d/%h/%h",
                   c, out_fmt, out_imm, out_imm_en, out_tag, exp_q[0].fmt32, exp_q[0].imm32,
                   exp_q[0].tag);
        end
        n_vec++;
        if ({out_fmt64, out_imm64, out_imm_en64, out_tag64} !== {exp_q[0].fmt64,
            exp_q[0].imm64, exp_q[0].fmt64 != 3'd0, exp_q[0].tag}) begin
          n_err++;
          $display("FAIL rand64 cyc %0d: got fmt=%0d imm=%h tag=%h, want %0d/%h/%h",
                   c, out_fmt64, out_imm64, out_tag64, exp_q[0].fmt64, exp_q[0].imm64,
                   exp_q[0].tag);
        end
      end
      step();
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    while (exp_q.size() < 2) begin
      in_valid = 1'b1;
      in_instr = rand_instr();
      in_tag   = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_ready: got in_ready=%0b, want 0", in_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, in_ready, out_fmt, out_tag, out_valid64, in_ready64} !==
        {1'b0, 1'b1, 3'd0, 8'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL async_reset: got v=%0b rdy=%0b fmt=%0d tag=%h v64=%0b rdy64=%0b",
               out_valid, in_ready, out_fmt, out_tag, out_valid64, in_ready64);
    end
    #1 rst_n = 1'b1;
    exp_q.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h123450B7;
    in_tag    = 8'h5A;
    step();
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, out_fmt, out_imm, out_tag, out_imm64} !==
        {1'b1, 3'd4, 32'h12345000, 8'h5A, 64'h0000000012345000}) begin
      n_err++;
      $display("FAIL post_reset: got v=%0b fmt=%0d imm=%h tag=%h imm64=%h",
               out_valid, out_fmt, out_imm, out_tag, out_imm64);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_drain: got out_valid=%0b, want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/immgen_pipe.md
IMMGEN_PIPE -- requirements
Module: immgen_pipe

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, giving the immediate output width (32 or 64).
REQ-002 The module SHALL have parameter TAG_W, default 8, giving the width of an opaque sideband tag.
REQ-003 The module SHALL have parameter CSR_EN, default 1; when 1, CSR-immediate (zimm) decode is enabled.
REQ-004 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  upstream instruction valid.
REQ-008 in_ready  output  1  block can accept; registered, equals NOT skid-occupied.
REQ-009 in_instr  input  32  raw RV instruction.
REQ-010 in_tag  input  TAG_W  sideband passed through unchanged.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts.
REQ-013 out_imm  output  XLEN  decoded immediate.
REQ-014 out_imm_en  output  1  1 when out_fmt is not NONE.
REQ-015 out_fmt  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
REQ-016 out_tag  output  TAG_W  tag of the presented result.

Function
REQ-017 Transfers SHALL occur on a rising edge with valid&ready both high, on both ports independently.
REQ-018 Latency SHALL be 1 cycle (accept at edge N, out_valid at edge N); throughput SHALL be 1 per cycle with out_ready held high.
REQ-019 Buffering SHALL be one output register plus one skid register; states EMPTY, ONE, FULL.
REQ-020 EMPTY->ONE on accept; ONE->EMPTY on drain without accept; ONE->FULL on accept without drain; FULL->ONE on drain; ONE stays ONE on simultaneous accept and drain.
REQ-021 In FULL, in_ready SHALL be 0; on drain the skid entry SHALL move to the output register, preserving order.
REQ-022 Decode SHALL happen before the register stage; the skid SHALL store decoded results.
REQ-023 Any instruction with instr[1:0] != 2'b11 SHALL decode to fmt NONE, imm 0.
REQ-024 Opcode 0000011, 0010011 or 1100111 SHALL give I: sign-extend instr[31:20].
REQ-025 Opcode 0011011 SHALL give I when XLEN=64, and NONE otherwise.
REQ-026 Opcode 0100011 SHALL give S: sign-extend {instr[31:25],instr[11:7]}.
REQ-027 Opcode 1100011 SHALL give B: sign-extend {instr[31],instr[7],instr[30:25],instr[11:8],0}.
REQ-028 Opcode 0110111 or 0010111 SHALL give U: sign-extend {instr[31:12],12'b0}.
REQ-029 Opcode 1101111 SHALL give J: sign-extend {instr[31],instr[19:12],instr[20],instr[30:21],0}.
REQ-030 Opcode 1110011 with funct3[2]=1 and CSR_EN=1 SHALL give Z: zero-extend instr[19:15]; all other SYSTEM cases SHALL give NONE.
REQ-031 All other opcodes SHALL give fmt NONE, imm 0, out_imm_en 0.
REQ-032 Sign extension SHALL replicate instr[31] up to XLEN-1.
REQ-033 out_imm, out_fmt and out_tag SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-034 While rst_n=0: out_valid 0, out_imm 0, out_fmt 0, out_imm_en 0, out_tag 0, skid cleared, state EMPTY, in_ready 1, and no transfers.
REQ-035 Reset assertion mid-operation SHALL discard both buffered entries immediately, without waiting for a clock edge.

Verification
REQ-036 0xFFF00093 (addi -1), out_ready=1 -> next cycle out_valid=1, fmt 1, imm 0xFFFFFFFF, out_imm_en=1.
REQ-037 0x123450B7 (LUI) -> fmt 4, imm 0x12345000; with XLEN=64 -> 0x0000000012345000.
REQ-038 0xFE000EE3 (beq -4) -> fmt 3, imm 0xFFFFFFFC; 0x300FD073 (csrrwi zimm=31) -> fmt 6, imm 0x0000001F.
REQ-039 out_ready=0, 3 back-to-back valid instrs, tags 1/2/3 -> in_ready falls after 2 accepts; raise out_ready -> tags 1,2,3 emerge in order, with no loss or duplication.
REQ-040 0x00000013 with in_instr[1:0] forced to 00, plus opcode 0110011 (R-type) -> fmt 0, imm 0, out_imm_en 0.
REQ-041 In FULL, pulse rst_n low between edges -> out_valid 0 and in_ready 1 immediately; the next accept produces a fresh result one cycle later.
